// File: rtl/counter_sweep_pkg.sv
// Shared types and defaults for the counter sweep sequencer.
// Direction encoding matches the up/down counter's direction input.
package counter_sweep_pkg;

   localparam int WIDTH_DEFAULT   = 8;
   localparam int SWEEP_W_DEFAULT = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SEEK  = 3'd2,
      UP    = 3'd3,
      DOWN  = 3'd4,
      DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/counter.sv
// Plain up/down counter with synchronous active-high reset.
// It is steered externally by counter_sweep_ctrl.
module counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             direction,
   output logic [WIDTH-1:0] counter_out
);

   // NOTE: sequential state is always written with non-blocking assignments so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter_out <= '0;
      end else if (enable) begin
         if (direction) counter_out <= counter_out + WIDTH'(1);
         else           counter_out <= counter_out - WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Closed-loop sequencer that walks the counter through N lo->hi->lo triangles.
// Enable/direction are decoded combinationally so the counter turns with no dwell.
module counter_sweep_ctrl
   import counter_sweep_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int SWEEP_W = SWEEP_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [SWEEP_W-1:0] sweeps,
   input  logic               pause,
   input  logic               abort,
   input  logic [WIDTH-1:0]   cnt_value,
   output logic               cnt_rst,
   output logic               cnt_enable,
   output logic               cnt_direction,
   output logic               busy,
   output logic               done,
   output logic               cfg_err,
   output logic [SWEEP_W-1:0] sweeps_done
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
   logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
   logic [SWEEP_W-1:0] sweeps_done_q, sweeps_done_d;
   logic               cfg_err_q, cfg_err_d;
   logic [SWEEP_W:0]   sd_inc;
   logic               bad_cfg;

   assign bad_cfg = (lo >= hi) || (sweeps == '0);
   assign sd_inc  = {1'b0, sweeps_done_q} + (SWEEP_W+1)'(1);

   // NOTE: every signal driven here gets a default first, so no path through the
   // case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      sweeps_d      = sweeps_q;
      sweeps_done_d = sweeps_done_q;
      cfg_err_d     = 1'b0;
      cnt_enable    = 1'b0;
      cnt_direction = DIR_DOWN;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (bad_cfg) begin
                  cfg_err_d = 1'b1;
               end else begin
                  lo_d          = lo;
                  hi_d          = hi;
                  sweeps_d      = sweeps;
                  sweeps_done_d = '0;
                  state_d       = CLEAR;
               end
            end
         end
         CLEAR: state_d = SEEK;
         SEEK: begin
            if (!pause) begin
               cnt_enable    = 1'b1;
               cnt_direction = DIR_UP;
               if (cnt_value == lo_q) state_d = UP;
            end
         end
         UP: begin
            if (!pause) begin
               cnt_enable = 1'b1;
               if (cnt_value == hi_q) begin
                  cnt_direction = DIR_DOWN;
                  state_d       = DOWN;
               end else begin
                  cnt_direction = DIR_UP;
               end
            end
         end
         DOWN: begin
            if (!pause) begin
               if (cnt_value != lo_q) begin
                  cnt_enable    = 1'b1;
                  cnt_direction = DIR_DOWN;
               end else begin
                  // Saturate at the requested count; a turn at lo closes one sweep.
                  sweeps_done_d = (sd_inc >= {1'b0, sweeps_q}) ? sweeps_q
                                                               : sd_inc[SWEEP_W-1:0];
                  if (sd_inc < {1'b0, sweeps_q}) begin
                     cnt_enable    = 1'b1;
                     cnt_direction = DIR_UP;
                     state_d       = UP;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d       = IDLE;
         sweeps_done_d = sweeps_done_q;
         cnt_enable    = 1'b0;
         cnt_direction = DIR_DOWN;
      end
      if (rst) cnt_enable = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sweeps_done_q <= '0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sweeps_done_q <= sweeps_done_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   // NOTE: the configuration registers are deliberately left out of reset; they
   // are only consulted outside IDLE and are always reloaded by an accepted start.
   always_ff @(posedge clk) begin
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
   end

   assign cnt_rst     = rst | (state_q == CLEAR);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE) && !abort;
   assign cfg_err     = cfg_err_q;
   assign sweeps_done = sweeps_done_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Closed-loop bench: sequencer plus counter, checked against a trajectory model
// and a scoreboard of expected done/cfg_err events.
module tb_counter_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, pause, abort;
   logic [7:0] lo, hi;
   logic [3:0] sweeps;
   logic [7:0] cnt_value;
   logic       cnt_rst, cnt_enable, cnt_direction;
   logic       busy, done, cfg_err;
   logic [3:0] sweeps_done;

   always #5 clk = ~clk;

   counter_sweep_ctrl #(.WIDTH(8), .SWEEP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .sweeps(sweeps),
      .pause(pause), .abort(abort), .cnt_value(cnt_value),
      .cnt_rst(cnt_rst), .cnt_enable(cnt_enable), .cnt_direction(cnt_direction),
      .busy(busy), .done(done), .cfg_err(cfg_err), .sweeps_done(sweeps_done)
   );

   counter #(.WIDTH(8)) u_cnt (
      .clk(clk), .rst(cnt_rst), .enable(cnt_enable),
      .direction(cnt_direction), .counter_out(cnt_value)
   );

   typedef enum int {EV_DONE = 0, EV_CFG = 1} ev_e;
   typedef struct {
      ev_e kind;
      int  cyc;
      int  sd;
      int  val;
   } ev_t;
   ev_t sbq[$];

   typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_DONE} mode_e;
   mode_e m_mode = M_IDLE;
   int    m_lo, m_hi, m_sw, m_k, m_val, m_sd, m_start, m_npause;
   int    cyc = 0;
   int    c_prev;
   bit    chk_en = 1'b0;
   int    total = 0;
   int    bad   = 0;

   // Counter value at trajectory position k: 0..lo, then triangles lo..hi..lo.
   function automatic int traj(int k, int l, int h);
      int d, m;
      d = h - l;
      if (k <= l) return k;
      m = (k - l) % (2 * d);
      return (m <= d) ? (l + m) : (h - (m - d));
   endfunction

   function automatic int last_pos(int l, int h, int s);
      return l + 2 * s * (h - l);
   endfunction

   function automatic bit low_turn(int k, int l, int h);
      return (k > l) && (((k - l) % (2 * (h - l))) == 0);
   endfunction

   task automatic push_ev(input ev_e kind, input int c, input int sd, input int val);
      ev_t e;
      e.kind = kind; e.cyc = c; e.sd = sd; e.val = val;
      sbq.push_back(e);
   endtask

   always @(posedge clk) begin
      c_prev = cyc;
      cyc    = cyc + 1;
      if (rst) begin
         m_mode = M_IDLE;
         m_sd   = 0;
         m_val  = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (start) begin
               if ((lo >= hi) || (sweeps == 0)) begin
                  push_ev(EV_CFG, cyc, m_sd, m_val);
               end else begin
                  m_lo = lo; m_hi = hi; m_sw = sweeps;
                  m_sd = 0; m_start = c_prev; m_npause = 0;
                  m_mode = M_CLEAR;
               end
            end
            M_CLEAR: begin
               m_val  = 0;
               m_k    = 0;
               m_mode = abort ? M_IDLE : M_RUN;
            end
            M_RUN: begin
               if (abort) begin
                  m_mode = M_IDLE;
               end else if (pause) begin
                  m_npause++;
               end else if (m_k == last_pos(m_lo, m_hi, m_sw)) begin
                  m_sd++;
                  m_mode = M_DONE;
                  push_ev(EV_DONE,
                          m_start + m_lo + 2 * m_sw * (m_hi - m_lo) + 3 + m_npause,
                          m_sd, m_val);
               end else begin
                  if (low_turn(m_k, m_lo, m_hi)) m_sd++;
                  m_k++;
                  m_val = traj(m_k, m_lo, m_hi);
               end
            end
            M_DONE: m_mode = M_IDLE;
            default: m_mode = M_IDLE;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d, wanted %0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("cnt_value", cnt_value, m_val);
         check("busy", busy, m_mode != M_IDLE);
         check("sweeps_done", sweeps_done, m_sd);
         if (done || cfg_err) begin
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_event at cycle %0d: done=%0b cfg_err=%0b, wanted none",
                        cyc, done, cfg_err);
            end else begin
               ev_t e;
               e = sbq.pop_front();
               check("ev_kind", done ? 0 : 1, int'(e.kind));
               check("ev_cycle", cyc, e.cyc);
               check("ev_sweeps_done", sweeps_done, e.sd);
               check("ev_value", cnt_value, e.val);
            end
         end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL missed_event at cycle %0d: got nothing, wanted kind %0d at cycle %0d",
                     cyc, int'(sbq[0].kind), sbq[0].cyc);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic do_start(input int l, input int h, input int s);
      lo = 8'(l); hi = 8'(h); sweeps = 4'(s); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int ppct, input int apct);
      int n;
      n = 0;
      while (m_mode != M_IDLE && n < 5000) begin
         pause  = ($urandom_range(99) < ppct);
         abort  = (m_mode == M_RUN) && ($urandom_range(999) < apct);
         start  = ($urandom_range(15) == 0);
         lo     = 8'($urandom);
         hi     = 8'($urandom);
         sweeps = 4'($urandom);
         @(negedge clk);
         n++;
      end
      pause = 1'b0; abort = 1'b0; start = 1'b0;
      if (m_mode != M_IDLE) begin
         total++; bad++;
         $display("FAIL idle_timeout at cycle %0d: still busy, wanted idle", cyc);
      end
   endtask

   task automatic wait_for(input int v, input bit up);
      int n;
      n = 0;
      while (n < 3000) begin
         if (m_mode == M_RUN && m_val == v && m_k < last_pos(m_lo, m_hi, m_sw) &&
             ((traj(m_k + 1, m_lo, m_hi) > v) == up))
            return;
         @(negedge clk);
         n++;
      end
      total++; bad++;
      $display("FAIL wait_timeout at cycle %0d: value %0d never reached, wanted %0d", cyc, m_val, v);
   endtask

   task automatic run(input int l, input int h, input int s, input int ppct, input int apct);
      do_start(l, h, s);
      wait_idle(ppct, apct);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
      lo = '0; hi = '0; sweeps = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      run(2, 5, 1, 0, 0);
      run(0, 3, 3, 0, 0);
      run(5, 5, 1, 0, 0);
      run(3, 7, 0, 0, 0);
      run(9, 2, 2, 0, 0);
      run(250, 255, 2, 0, 0);

      do_start(2, 8, 1);
      wait_for(4, 1'b1);
      pause = 1'b1;
      repeat (4) @(negedge clk);
      pause = 1'b0;
      wait_idle(0, 0);

      do_start(0, 6, 1);
      wait_for(3, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (3) @(negedge clk);
      run(2, 5, 1, 0, 0);

      do_start(0, 10, 2);
      wait_for(5, 1'b1);
      rst = 1'b1; start = 1'b1; lo = 8'd1; hi = 8'd9; sweeps = 4'd1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         int l, h, s;
         l = $urandom_range(40);
         h = l + $urandom_range(25);
         s = $urandom_range(4);
         if ($urandom_range(7) == 0) begin
            int t;
            t = l; l = h; h = t;
         end
         run(l, h, s, 10, 3);
         pause = 1'($urandom_range(1));
         abort = 1'($urandom_range(1));
         @(negedge clk);
         pause = 1'b0; abort = 1'b0;
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog at cycle %0d: bench did not finish in time", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the 8-bit up/down counter (`counter`: clk, rst, enable, direction, counter_out; direction 1 = up, synchronous reset to 0).
- Drives the counter's rst, enable and direction inputs, and reads counter_out back.
- After a start request it produces N triangle sweeps lo -> hi -> lo, then pulses done and holds the counter at lo.
- Sits beside the counter in the Ex3 top level; the counter instance stays unchanged.

Parameters:
- WIDTH, 8, counter and bound width; must match the counter.
- SWEEP_W, 4, width of the sweep-count field.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- lo  input  WIDTH  lower turning point; latched on accepted start.
- hi  input  WIDTH  upper turning point; latched on accepted start.
- sweeps  input  SWEEP_W  number of lo->hi->lo sweeps; latched on accepted start.
- pause  input  1  freezes the counter while high.
- abort  input  1  cancels the sequence; returns to IDLE.
- cnt_value  input  WIDTH  counter_out fed back from the counter.
- cnt_rst  output  1  to counter rst.
- cnt_enable  output  1  to counter enable.
- cnt_direction  output  1  to counter direction (1 = up).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on completion.
- cfg_err  output  1  one-cycle pulse on a rejected start.
- sweeps_done  output  SWEEP_W  completed sweeps in the current or last run.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE; sweeps_done = 0; done = cfg_err = 0.
  - cnt_rst = rst | (state == CLEAR), so the counter resets with the controller.
- Priority: rst > abort > pause > normal operation.
- Outputs cnt_enable and cnt_direction are combinational from the registered state and cnt_value. Nothing is registered in the loop, so the counter turns exactly at lo/hi with no dwell cycle.
- IDLE:
  - cnt_enable = 0, cnt_direction = 0.
  - On start: if lo >= hi or sweeps == 0, pulse cfg_err next cycle and stay IDLE.
  - Otherwise latch lo/hi/sweeps, clear sweeps_done, go to CLEAR.
  - start while busy is ignored.
- CLEAR: one cycle with cnt_rst = 1 and cnt_enable = 0; then go to SEEK.
- SEEK:
  - If cnt_value != lo: enable = 1, dir = up.
  - If cnt_value == lo: enable = 1, dir = up, go to UP (counter steps lo -> lo+1). lo = 0 spends one cycle here.
- UP:
  - If cnt_value != hi: enable = 1, dir = up.
  - If cnt_value == hi: enable = 1, dir = down, go to DOWN.
- DOWN:
  - If cnt_value != lo: enable = 1, dir = down.
  - If cnt_value == lo: increment sweeps_done.
    - If sweeps_done + 1 < sweeps: enable = 1, dir = up, go to UP.
    - Else: enable = 0, go to DONE.
- DONE: enable = 0, done = 1 for this one cycle; then go to IDLE. The counter holds at lo.
- pause high in SEEK/UP/DOWN: enable = 0, state and sweeps_done held. Turning-point logic is evaluated only while pause is low.
- abort in any non-IDLE state:
  - enable = 0, next state IDLE, no done pulse.
  - sweeps_done keeps its value; the counter keeps its value.
- Latency from accepted start to the done cycle (no pause): lo + 2*sweeps*(hi-lo) + 3 cycles.
- Width rules:
  - Comparisons are unsigned equality and >= only; no wrap is ever commanded, since lo < hi <= 2^WIDTH-1.
  - sweeps_done saturates at sweeps.
- Upper-bound limit: hi = 255 is legal; the counter never receives up-enable at 255.

Decomposition:
- Package counter_sweep_pkg holds:
  - state enum IDLE/CLEAR/SEEK/UP/DOWN/DONE (3-bit);
  - DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - default WIDTH.
- Single module, no sub-module: FSM, config registers and output decode are one unit.
- The bench instantiates counter_sweep_ctrl with the existing counter in closed loop.

Test Plan:
- Basic sweep: lo=2, hi=5, sweeps=1, start for 1 cycle -> cnt_value sequence 0,1,2,3,4,5,4,3,2. done high exactly 11 cycles after start accepted. busy falls the cycle after done. sweeps_done=1. Counter holds 2.
- Multiple sweeps with lo=0: lo=0, hi=3, sweeps=3 -> three full 0..3..0 triangles. done at cycle 0+18+3 = 21. sweeps_done=3. Never more than 1 cycle at lo or hi.
- Config errors:
  - lo=5, hi=5 -> cfg_err pulses 1 cycle, busy stays 0, counter untouched.
  - sweeps=0 -> same response.
- Pause: pause for 4 cycles while cnt_value=4 going up -> value stays 4 for 4 cycles, then resumes upward. done is delayed by exactly 4 cycles.
- Abort and restart: abort in DOWN at cnt_value=3 -> next cycle busy=0, no done, cnt_value stays 3. A new start re-clears the counter to 0 and the sweep runs normally.
- Reset mid-run: rst high for 1 cycle during UP -> state IDLE, cnt_value=0, done=0, sweeps_done=0. start with the same cycle as rst is ignored.
